// File: rtl/mips_rf_pkg.sv
// Shared register-file types: index/data widths, the hard-wired zero register
// and the packed writeback entry held in the queue.
package mips_rf_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_fwd_match.sv
// Forwarding lookup over the pending writes: the output stage plus every live
// FIFO slot. Later (younger) matches overwrite earlier ones, so the youngest
// pending value for the requested register is returned. Register 0 never hits.
module rf_fwd_match #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]        lookup_reg,
    input  logic [ADDR_W-1:0]        ent_reg  [DEPTH],
    input  logic [DATA_W-1:0]        ent_data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head_ptr,
    input  logic [$clog2(DEPTH):0]   occupancy,
    input  logic                     out_valid,
    input  logic [ADDR_W-1:0]        out_reg,
    input  logic [DATA_W-1:0]        out_data,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data
);
    import mips_rf_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Oldest-to-youngest scan: output stage first, then head .. tail-1.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head_ptr;
        if (lookup_reg != '0) begin
            if (out_valid && (out_reg == lookup_reg)) begin
                fwd_hit  = 1'b1;
                fwd_data = out_data;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_ptr + PTR_W'(k);
                if (((PTR_W+1)'(k) < occupancy) && (ent_reg[idx] == lookup_reg)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = ent_data[idx];
                end
            end
        end
    end

endmodule

// File: rtl/rf_writeback_queue.sv
// Writeback queue feeding the register file write port. Requests are buffered
// in a small circular FIFO and issued one per cycle into registered rf_* outputs
// that stay stable across the register file's negedge write. Two forwarding
// ports let decode see values that have not reached the register file yet.
module rf_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [ADDR_W-1:0]        wb_reg,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     drain_en,
    input  logic                     flush,
    output logic                     rf_write_enable,
    output logic [ADDR_W-1:0]        rf_write_register,
    output logic [DATA_W-1:0]        rf_in_data,
    input  logic [ADDR_W-1:0]        fwd_reg1,
    input  logic [ADDR_W-1:0]        fwd_reg2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [DATA_W-1:0]        fwd_data1,
    output logic [DATA_W-1:0]        fwd_data2,
    output logic [$clog2(DEPTH):0]   pending_count,
    output logic                     empty,
    output logic                     full
);
    import mips_rf_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    wb_entry_t         mem [DEPTH];
    logic [ADDR_W-1:0] ent_reg  [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic              push_acc;
    logic              pop_go;

    assign full          = (count == (PTR_W+1)'(DEPTH));
    assign empty         = (count == '0);
    assign wb_ready      = !full;
    assign pending_count = count;

    // Writes to $zero complete the handshake but are never stored.
    assign push_acc = wb_valid && wb_ready && (wb_reg != ZERO_REG);
    assign pop_go   = drain_en && !empty;

    // Control state and the issued-write registers; flush beats push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
            rf_write_enable   <= 1'b0;
            rf_write_register <= '0;
            rf_in_data        <= '0;
        end else if (flush) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            rf_write_enable <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_go) begin
                rd_ptr            <= rd_ptr + PTR_W'(1);
                rf_write_enable   <= 1'b1;
                rf_write_register <= mem[rd_ptr].dst;
                rf_in_data        <= mem[rd_ptr].data;
            end else begin
                rf_write_enable <= 1'b0;
            end
            case ({push_acc, pop_go})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; slots are only meaningful while covered by count.
    always_ff @(posedge clk) begin
        if (push_acc && !flush) begin
            mem[wr_ptr] <= '{dst: wb_reg, data: wb_data};
        end
    end

    // Split the stored entries into per-field arrays for the lookup blocks.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_reg[i]  = mem[i].dst;
            ent_data[i] = mem[i].data;
        end
    end

    rf_fwd_match #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd1 (
        .lookup_reg (fwd_reg1),
        .ent_reg    (ent_reg),
        .ent_data   (ent_data),
        .head_ptr   (rd_ptr),
        .occupancy  (count),
        .out_valid  (rf_write_enable),
        .out_reg    (rf_write_register),
        .out_data   (rf_in_data),
        .fwd_hit    (fwd_hit1),
        .fwd_data   (fwd_data1)
    );

    rf_fwd_match #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd2 (
        .lookup_reg (fwd_reg2),
        .ent_reg    (ent_reg),
        .ent_data   (ent_data),
        .head_ptr   (rd_ptr),
        .occupancy  (count),
        .out_valid  (rf_write_enable),
        .out_reg    (rf_write_register),
        .out_data   (rf_in_data),
        .fwd_hit    (fwd_hit2),
        .fwd_data   (fwd_data2)
    );

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed scenarios followed by random traffic,
// checked against a queue-based reference model and a write scoreboard.
module tb_rf_writeback_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic          clk;
    logic          rst_n;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_reg;
    logic [DW-1:0] wb_data;
    logic          drain_en;
    logic          flush;
    logic          rf_write_enable;
    logic [AW-1:0] rf_write_register;
    logic [DW-1:0] rf_in_data;
    logic [AW-1:0] fwd_reg1;
    logic [AW-1:0] fwd_reg2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
    logic [$clog2(DEPTH):0] pending_count;
    logic          empty;
    logic          full;

    rf_writeback_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wb_valid          (wb_valid),
        .wb_ready          (wb_ready),
        .wb_reg            (wb_reg),
        .wb_data           (wb_data),
        .drain_en          (drain_en),
        .flush             (flush),
        .rf_write_enable   (rf_write_enable),
        .rf_write_register (rf_write_register),
        .rf_in_data        (rf_in_data),
        .fwd_reg1          (fwd_reg1),
        .fwd_reg2          (fwd_reg2),
        .fwd_hit1          (fwd_hit1),
        .fwd_hit2          (fwd_hit2),
        .fwd_data1         (fwd_data1),
        .fwd_data2         (fwd_data2),
        .pending_count     (pending_count),
        .empty             (empty),
        .full              (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    // Reference model: pending writes in arrival order plus the issued write.
    ent_t          mq[$];
    ent_t          exp_q[$];
    bit            out_v;
    logic [AW-1:0] out_r;
    logic [DW-1:0] out_d;
    logic [DW-1:0] rf_mem [32];

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_fwd(input logic [AW-1:0] r, output bit hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (r != '0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].r == r) begin
                    hit = 1'b1;
                    d   = mq[i].d;
                    break;
                end
            end
            if (!hit && out_v && out_r == r) begin
                hit = 1'b1;
                d   = out_d;
            end
        end
    endfunction

    task automatic check_state();
        bit            h;
        logic [DW-1:0] d;
        chk("wb_ready",      32'(wb_ready),          32'(mq.size() < DEPTH));
        chk("pending_count", 32'(pending_count),     32'(mq.size()));
        chk("empty",         32'(empty),             32'(mq.size() == 0));
        chk("full",          32'(full),              32'(mq.size() == DEPTH));
        chk("rf_we",         32'(rf_write_enable),   32'(out_v));
        chk("rf_reg",        32'(rf_write_register), 32'(out_r));
        chk("rf_data",       rf_in_data,             out_d);
        model_fwd(fwd_reg1, h, d);
        chk("fwd_hit1",  32'(fwd_hit1), 32'(h));
        chk("fwd_data1", fwd_data1,     d);
        model_fwd(fwd_reg2, h, d);
        chk("fwd_hit2",  32'(fwd_hit2), 32'(h));
        chk("fwd_data2", fwd_data2,     d);
    endtask

    function automatic void model_step(input bit v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                                       input bit drn, input bit fl);
        bit   acc;
        ent_t e;
        if (fl) begin
            mq.delete();
            out_v = 1'b0;
        end else begin
            acc = v && (mq.size() < DEPTH);
            if (drn && mq.size() > 0) begin
                e     = mq.pop_front();
                out_v = 1'b1;
                out_r = e.r;
                out_d = e.d;
                exp_q.push_back(e);
            end else begin
                out_v = 1'b0;
            end
            if (acc && r != '0) begin
                e.r = r;
                e.d = d;
                mq.push_back(e);
            end
        end
    endfunction

    // Called at posedge+1: drive, check pre-edge state, advance model, cross edge.
    task automatic cycle(input bit v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                         input bit drn, input bit fl, input logic [AW-1:0] f1, input logic [AW-1:0] f2);
        wb_valid = v;
        wb_reg   = r;
        wb_data  = d;
        drain_en = drn;
        flush    = fl;
        fwd_reg1 = f1;
        fwd_reg2 = f2;
        #2;
        check_state();
        model_step(v, r, d, drn, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit drn, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, drn, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_we",    32'(rf_write_enable),   32'd0);
        chk("rst_reg",   32'(rf_write_register), 32'd0);
        chk("rst_data",  rf_in_data,             32'd0);
        chk("rst_count", 32'(pending_count),     32'd0);
        chk("rst_empty", 32'(empty),             32'd1);
        chk("rst_full",  32'(full),              32'd0);
        mq.delete();
        exp_q.delete();
        out_v = 1'b0;
        out_r = '0;
        out_d = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard: every issued write must match the next expected one.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rf_write_enable) begin
                rf_mem[rf_write_register] = rf_in_data;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got reg %0d data %h expected no write", rf_write_register, rf_in_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rf_write_register !== e.r || rf_in_data !== e.d) begin
                        errors++;
                        $display("FAIL write_order: got reg %0d data %h expected reg %0d data %h",
                                 rf_write_register, rf_in_data, e.r, e.d);
                    end
                end
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        wb_valid = 1'b0;
        wb_reg   = '0;
        wb_data  = '0;
        drain_en = 1'b0;
        flush    = 1'b0;
        fwd_reg1 = '0;
        fwd_reg2 = '0;
        rst_n    = 1'b1;
        for (int i = 0; i < 32; i++) rf_mem[i] = '0;
        #1;
        do_reset();

        // Single write: accepted at edge 1, issued after edge 2, no bypass.
        cycle(1'b1, 5'd8, 32'hDEADBEEF, 1'b1, 1'b0, 5'd8, 5'd0);
        chk("single_no_bypass", 32'(rf_write_enable), 32'd0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 5'd8, 5'd0);
        chk("single_we",   32'(rf_write_enable),   32'd1);
        chk("single_reg",  32'(rf_write_register), 32'd8);
        chk("single_data", rf_in_data,             32'hDEADBEEF);
        idle(1'b1, 1);
        chk("rf_mem_r8", rf_mem[8], 32'hDEADBEEF);

        // Fill to full with draining held off; the fifth push is refused.
        for (int i = 0; i < 4; i++) cycle(1'b1, 5'(9 + i), 32'(100 + i), 1'b0, 1'b0, 5'd10, 5'd12);
        chk("fill_full",  32'(full),     32'd1);
        chk("fill_ready", 32'(wb_ready), 32'd0);
        cycle(1'b1, 5'd13, 32'hBAD, 1'b0, 1'b0, 5'd13, 5'd9);
        chk("fill_count", 32'(pending_count), 32'd4);
        idle(1'b1, 6);

        // Write to $zero is swallowed.
        cycle(1'b1, 5'd0, 32'h55, 1'b1, 1'b0, 5'd0, 5'd0);
        chk("zero_count", 32'(pending_count), 32'd0);
        idle(1'b1, 2);

        // Youngest pending value wins; unrelated register misses.
        cycle(1'b1, 5'd9, 32'd1, 1'b0, 1'b0, 5'd9, 5'd3);
        cycle(1'b1, 5'd9, 32'd2, 1'b0, 1'b0, 5'd9, 5'd3);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 5'd9, 5'd3);
        chk("fwd_young_hit",  32'(fwd_hit1), 32'd1);
        chk("fwd_young_data", fwd_data1,     32'd2);
        chk("fwd_miss_hit",   32'(fwd_hit2), 32'd0);
        chk("fwd_miss_data",  fwd_data2,     32'd0);

        // Flush collides with push and pop: nothing survives, reg 13 never written.
        cycle(1'b1, 5'd13, 32'h1313, 1'b1, 1'b1, 5'd13, 5'd9);
        chk("flush_count", 32'(pending_count),   32'd0);
        chk("flush_we",    32'(rf_write_enable), 32'd0);
        idle(1'b1, 3);

        // Asynchronous reset mid-drain with three entries still queued.
        for (int i = 0; i < 4; i++) cycle(1'b1, 5'(20 + i), 32'(32'hA0 + i), 1'b0, 1'b0, '0, '0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
        chk("pre_rst_we",    32'(rf_write_enable), 32'd1);
        chk("pre_rst_count", 32'(pending_count),   32'd3);
        do_reset();
        idle(1'b1, 3);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 99) < 60),
                  5'($urandom_range(0, 15)),
                  $urandom,
                  ($urandom_range(0, 99) < 65),
                  ($urandom_range(0, 99) < 4),
                  5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)));
        end

        idle(1'b1, DEPTH + 3);
        @(negedge clk);
        #1;
        chk("all_writes_seen", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
